division_sequencer: RTL and testbench

- Upstream feeder and downstream collector for the iterative Division unit.
- Queues operand pairs from a valid/ready producer in a small FIFO.
- Issues one pair at a time to the divider by pulsing start and holding the operands stable, then waits a fixed latency.
- Captures q/r into an output register with a valid/ready handshake. Divide-by-zero is resolved locally without starting the divider.

---
 rtl/division_sequencer.sv | 176 +++++++++++++++++
 tb/tb_division_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/division_sequencer.sv
// Operand FIFO, divider issue sequencer and single-entry result register.
// Divide-by-zero is answered locally without starting the divider.
module division_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DIV_LATENCY = 34,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_divzero,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  // FIFO storage and pointers
  logic [WIDTH-1:0] mem_a_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_b_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      fcnt_q, fcnt_d;
  logic             full, empty;
  logic             push, pop;
  logic [WIDTH-1:0] head_a, head_b;

  // Sequencer state and registered outputs
  state_e           state_q, state_d;
  logic [CW-1:0]    lcnt_q, lcnt_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] diva_q, diva_d;
  logic [WIDTH-1:0] divb_q, divb_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] oq_q, oq_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic             dz_q, dz_d;

  assign full   = (fcnt_q == DEPTH_C);
  assign empty  = (fcnt_q == '0);
  assign push   = in_valid && !full;
  assign head_a = mem_a_q[rd_q];
  assign head_b = mem_b_q[rd_q];

  // Operand storage; contents need no reset, only pointers do
  always_ff @(posedge clock) begin
    if (push) begin
      mem_a_q[wr_q] <= in_a;
      mem_b_q[wr_q] <= in_b;
    end
  end

  // Pointer and occupancy update; wrap is free for power-of-two depth
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (AW + 1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW + 1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Issue/wait sequencing and result capture
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    start_d = 1'b0;
    diva_d  = diva_q;
    divb_d  = divb_q;
    ov_d    = ov_q && !out_ready;
    oq_d    = oq_q;
    or_d    = or_q;
    dz_d    = dz_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !ov_q) begin
          pop    = 1'b1;
          diva_d = head_a;
          divb_d = head_b;
          if (head_b == '0) begin
            oq_d = '1;
            or_d = head_a;
            dz_d = 1'b1;
            ov_d = 1'b1;
          end else begin
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        lcnt_d  = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lcnt_q == '0) begin
          oq_d    = div_q;
          or_d    = div_r;
          dz_d    = 1'b0;
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          lcnt_d = lcnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any divider work in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
      state_q <= S_IDLE;
      lcnt_q  <= '0;
      start_q <= 1'b0;
      diva_q  <= '0;
      divb_q  <= '0;
      ov_q    <= 1'b0;
      oq_q    <= '0;
      or_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      start_q <= start_d;
      diva_q  <= diva_d;
      divb_q  <= divb_d;
      ov_q    <= ov_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready    = !full;
  assign div_start   = start_q;
  assign div_a       = diva_q;
  assign div_b       = divb_q;
  assign out_valid   = ov_q;
  assign out_q       = oq_q;
  assign out_r       = or_q;
  assign out_divzero = dz_q;
  assign busy        = !empty || (state_q != S_IDLE) || ov_q;

endmodule

// File: tb/tb_division_sequencer.sv
// Scoreboard bench for division_sequencer with a behavioural divider.
// Directed vectors; results are popped and checked by a monitor.
module tb_division_sequencer;

  localparam int W = 32;
  localparam int L = 34;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         div_start;
  logic [W-1:0] div_a, div_b;
  logic [W-1:0] div_q, div_r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q, out_r;
  logic         out_divzero;
  logic         busy;

  division_sequencer #(
    .WIDTH(W), .DIV_LATENCY(L), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r),
    .out_divzero(out_divzero), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nstarts = 0;
  int   nres = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural divider: junk until the latency has elapsed
  logic [W-1:0] mq, mr, ma, mb;
  int           mcnt = 0;
  bit           mact = 1'b0;
  bit           prev_start = 1'b0;

  always @(posedge clock) begin
    if (div_start && !reset) begin
      checks = checks + 1;
      if (prev_start) begin
        errors = errors + 1;
        $display("FAIL start_pulse: div_start high two cycles at cycle %0d", cyc);
      end
    end
    prev_start <= div_start;
    if (reset) begin
      mcnt <= 0;
      mact <= 1'b0;
    end else if (div_start) begin
      ma      <= div_a;
      mb      <= div_b;
      mq      <= div_a / div_b;
      mr      <= div_a % div_b;
      mcnt    <= L - 1;
      mact    <= 1'b1;
      nstarts <= nstarts + 1;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign div_q = (mact && mcnt == 0) ? mq : 32'hDEADBEEF;
  assign div_r = (mact && mcnt == 0) ? mr : 32'h0BADF00D;

  // Operands must stay put while the divider works
  always @(negedge clock) begin
    if (!reset && mact && mcnt > 0) begin
      checks = checks + 1;
      if (div_a !== ma || div_b !== mb) begin
        errors = errors + 1;
        $display("FAIL div_hold: got a=%h b=%h, want a=%h b=%h",
                 div_a, div_b, ma, mb);
      end
    end
  end

  // Monitor: every accepted result is compared to the queue head
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_result: got q=%h r=%h dz=%b, want none",
                 out_q, out_r, out_divzero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        nres = nres + 1;
        if (out_q !== e.q || out_r !== e.r || out_divzero !== e.dz) begin
          errors = errors + 1;
          $display("FAIL result%0d: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                   nres, out_q, out_r, out_divzero, e.q, e.r, e.dz);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one pair and, once accepted, queue its expected result
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r,
                      input logic dz, output int k);
    bit hs;
    int n;
    exp_t e;
    hs = 1'b0;
    n = 0;
    k = -1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!hs && n < 2000) begin
      hs = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (hs) begin
      e.q = q;
      e.r = r;
      e.dz = dz;
      sb.push_back(e);
      k = cyc;
    end else begin
      chk("send_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_valid(output int e);
    int n;
    n = 0;
    e = -1;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (out_valid) e = cyc;
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      step();
      n++;
    end
    chk({name, "_left"}, 64'(sb.size()), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int k, e, s0, bad, acc, nov;
    bit hs;
    exp_t x;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_out_q", 64'(out_q), 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);
    chk("rst_divzero", 64'(out_divzero), 64'd0);
    chk("rst_div_a", 64'(div_a), 64'd0);

    // 7/3 through the divider, exact latency
    s0 = nstarts;
    send(7, 3, 2, 1, 0, k);
    wait_valid(e);
    chk("lat_7_3", 64'(e), 64'(k + 36));
    chk("starts_7_3", 64'(nstarts - s0), 64'd1);
    step();
    chk("busy_after_hs", 64'(busy), 64'd0);
    chk("ov_after_hs", 64'(out_valid), 64'd0);

    // 5/0 bypass, no divider start
    s0 = nstarts;
    send(5, 0, 32'hFFFFFFFF, 5, 1, k);
    wait_valid(e);
    chk("lat_bypass_le2", 64'(e >= 0 && e <= k + 2), 64'd1);
    chk("starts_bypass", 64'(nstarts - s0), 64'd0);
    step();

    // Fill with the consumer stalled
    out_ready = 1'b0;
    send(7, 3, 2, 1, 0, k);
    send(100, 7, 14, 2, 0, k);
    send(9, 0, 32'hFFFFFFFF, 9, 1, k);
    send(1, 1, 1, 0, 0, k);
    send(8, 2, 4, 0, 0, k);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_a = 6;
    in_b = 4;
    in_valid = 1'b1;
    bad = 0;
    acc = 0;
    for (int i = 0; i < 45; i++) begin
      if (in_ready) acc++;
      step();
      if (out_valid && (out_q !== 2 || out_r !== 1)) bad++;
    end
    in_valid = 1'b0;
    chk("stall_accept", 64'(acc), 64'd0);
    chk("stall_ov", 64'(out_valid), 64'd1);
    chk("stall_stable", 64'(bad), 64'd0);
    drain("fill");

    // Push coinciding with a pop while two entries are queued
    out_ready = 1'b0;
    send(20, 6, 3, 2, 0, k);
    send(15, 4, 3, 3, 0, k);
    send(0, 9, 0, 0, 0, k);
    wait_valid(e);
    chk("pp_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_a = 50;
    in_b = 0;
    in_valid = 1'b1;
    hs = in_ready;
    step();
    in_valid = 1'b0;
    chk("pp_accept", 64'(hs), 64'd1);
    if (hs) begin
      x.q = 32'hFFFFFFFF;
      x.r = 50;
      x.dz = 1'b1;
      sb.push_back(x);
    end
    chk("pp_count", 64'(dut.fcnt_q), 64'd2);
    drain("pp");

    // Reset mid-wait with two entries queued
    out_ready = 1'b1;
    send(7, 3, 2, 1, 0, k);
    send(100, 7, 14, 2, 0, k);
    send(9, 0, 32'hFFFFFFFF, 9, 1, k);
    repeat (15) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    chk("abort_ov", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    nov = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_valid) nov++;
    end
    chk("abort_no_result", 64'(nov), 64'd0);
    send(7, 3, 2, 1, 0, k);
    wait_valid(e);
    chk("lat_after_abort", 64'(e), 64'(k + 36));
    drain("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
